// File: rtl/overlay_draw_arbiter_pkg.sv
// Shared FSM state encoding and overlay source indices for the overlay draw arbiter.
package middle_states_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        DRAW    = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4,
        RELEASE = 3'd5
    } state_t;

    // Index 0 has the highest grant priority.
    localparam int SRC_SAVE_GPA = 0;
    localparam int SRC_S1_START = 1;
    localparam int SRC_S1_CLEAR = 2;
    localparam int SRC_S2_START = 3;
    localparam int SRC_S2_CLEAR = 4;
    localparam int SRC_S3_START = 5;
    localparam int SRC_S3_CLEAR = 6;
    localparam int SRC_WIN      = 7;
    localparam int SRC_LOSE     = 8;

endpackage

// File: rtl/overlay_draw_arbiter_if.sv
// Bundle of request, drawer and VGA port signals between the game side and the overlay arbiter.
interface overlay_draw_arbiter_if #(
    parameter int N_SRC    = 9,
    parameter int COLOUR_W = 9,
    parameter int COORD_W  = 15
);
    logic [N_SRC-1:0]          req;
    logic [N_SRC-1:0]          drawer_done;
    logic [N_SRC*COLOUR_W-1:0] drawer_colour;
    logic [N_SRC*COORD_W-1:0]  drawer_coord;
    logic [N_SRC-1:0]          drawer_en;
    logic [N_SRC-1:0]          drawer_clr;
    logic [COLOUR_W-1:0]       colour;
    logic [COORD_W-1:0]        coordinates;
    logic                      VGA_write_enable;
    logic [N_SRC-1:0]          screen_done;
    logic                      busy;

    modport master (
        output req, drawer_done, drawer_colour, drawer_coord,
        input  drawer_en, drawer_clr, colour, coordinates, VGA_write_enable, screen_done, busy
    );

    modport slave (
        input  req, drawer_done, drawer_colour, drawer_coord,
        output drawer_en, drawer_clr, colour, coordinates, VGA_write_enable, screen_done, busy
    );
endinterface

// File: rtl/overlay_hold_timer.sv
// Display-hold counter: cleared by load, counts while enabled, flags terminal count HOLD_CYCLES-1.
module overlay_hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count_q <= '0;
        end else if (en && !tc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q == CNT_W'(HOLD_CYCLES - 1));
endmodule

// File: rtl/overlay_draw_arbiter.sv
// Grants one full-screen overlay drawer at a time onto the single VGA write port.
// Define OVERLAY_HOLD_EN to keep a finished overlay on screen for HOLD_CYCLES before acknowledging it.
module overlay_draw_arbiter
    import middle_states_pkg::*;
#(
    parameter int N_SRC       = 9,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int COLOUR_W    = 9,
    parameter int COORD_W     = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    overlay_draw_arbiter_if.slave bus
);
    localparam int GNT_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("overlay_draw_arbiter: HOLD_CYCLES must be at least 1");
    end

    state_t              state_q, state_d;
    logic [GNT_W-1:0]    grant_q, grant_d, pick;
    logic [N_SRC-1:0]    armed_q, armed_d, cand, grant_oh;
    logic                found, req_g, done_g;
    logic                vld_p0, vld_p1;
    logic [COLOUR_W-1:0] colour_p1;
    logic [COORD_W-1:0]  coord_p1;

    assign cand     = bus.req & armed_q;
    assign grant_oh = N_SRC'(1) << grant_q;
    assign req_g    = bus.req[grant_q];
    assign done_g   = bus.drawer_done[grant_q];

    // Scanning downwards leaves the lowest requesting index as the winner.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found = 1'b1;
                pick  = GNT_W'(i);
            end
        end
    end

`ifdef OVERLAY_HOLD_EN
    logic hold_tc;

    overlay_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (resetn),
        .load (state_q != HOLD),
        .en   (state_q == HOLD),
        .tc   (hold_tc)
    );
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        armed_d = armed_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = CLEAR;
                    grant_d = pick;
                end
            end
            CLEAR: state_d = req_g ? DRAW : IDLE;
            DRAW: begin
                if (!req_g) begin
                    state_d = IDLE;
                end else if (done_g) begin
`ifdef OVERLAY_HOLD_EN
                    state_d = HOLD;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef OVERLAY_HOLD_EN
            HOLD: begin
                if (!req_g) begin
                    state_d = IDLE;
                end else if (hold_tc) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                armed_d[grant_q] = 1'b0;
                state_d          = RELEASE;
            end
            // Stay disarmed until the game FSM leaves the screen that asked for this overlay.
            RELEASE: begin
                if (!req_g) begin
                    armed_d[grant_q] = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            armed_q <= '1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            armed_q <= armed_d;
        end
    end

    assign bus.drawer_clr  = (state_q == CLEAR) ? grant_oh : '0;
    assign bus.drawer_en   = (state_q == DRAW)  ? grant_oh : '0;
    assign bus.screen_done = (state_q == DONE)  ? grant_oh : '0;
    assign bus.busy        = (state_q != IDLE);

    // Stage p0 -> p1: granted drawer pixel registered onto the VGA port.
    assign vld_p0 = (state_q == DRAW) && req_g && !resetn;

    always_ff @(posedge clk) begin
        if (resetn) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        colour_p1 <= vld_p0 ? bus.drawer_colour[int'(grant_q)*COLOUR_W +: COLOUR_W] : '0;
        coord_p1  <= vld_p0 ? bus.drawer_coord[int'(grant_q)*COORD_W +: COORD_W] : '0;
    end

    assign bus.colour           = colour_p1;
    assign bus.coordinates      = coord_p1;
    assign bus.VGA_write_enable = vld_p1;
endmodule

// File: tb/tb_overlay_draw_arbiter.sv
// Directed bench for overlay_draw_arbiter with HOLD_CYCLES=4; follows OVERLAY_HOLD_EN like the design.
module tb_overlay_draw_arbiter;
    import middle_states_pkg::*;

    localparam int N  = 9;
    localparam int CW = 9;
    localparam int KW = 15;
    localparam int OW = N + N + 1 + CW + KW + N + 1;

    localparam logic [N-1:0] M_GPA  = N'(1) << SRC_SAVE_GPA;
    localparam logic [N-1:0] M_S1   = N'(1) << SRC_S1_START;
    localparam logic [N-1:0] M_S1C  = N'(1) << SRC_S1_CLEAR;
    localparam logic [N-1:0] M_S3S  = N'(1) << SRC_S3_START;
    localparam logic [N-1:0] M_LOSE = N'(1) << SRC_LOSE;
    localparam logic [N-1:0] Z      = '0;

    typedef struct {
        string          name;
        logic           rst;
        logic [N-1:0]   req;
        logic [N-1:0]   done;
        logic [OW-1:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    overlay_draw_arbiter_if #(.N_SRC(N), .COLOUR_W(CW), .COORD_W(KW)) bus ();

    overlay_draw_arbiter #(
        .N_SRC       (N),
        .HOLD_CYCLES (4),
        .COLOUR_W    (CW),
        .COORD_W     (KW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    function automatic logic [CW-1:0] col_of(input int i);
        return CW'(i * 37 + 11);
    endfunction

    function automatic logic [KW-1:0] crd_of(input int i);
        return KW'(i * 1000 + 123);
    endfunction

    // Expected output word; wsrc < 0 means no VGA write visible this cycle.
    function automatic logic [OW-1:0] ex(input logic [N-1:0] en, input logic [N-1:0] clr,
                                         input int wsrc, input logic [N-1:0] sd, input logic b);
        logic          w;
        logic [CW-1:0] c;
        logic [KW-1:0] k;
        w = (wsrc >= 0);
        c = w ? col_of(wsrc) : '0;
        k = w ? crd_of(wsrc) : '0;
        return {en, clr, w, c, k, sd, b};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.drawer_en, bus.drawer_clr, bus.VGA_write_enable, bus.colour,
                bus.coordinates, bus.screen_done, bus.busy};
    endfunction

    task automatic add(input string name, input logic rst, input logic [N-1:0] req,
                       input logic [N-1:0] done, input logic [OW-1:0] exp);
        vec_t v;
        v.name = name;
        v.rst  = rst;
        v.req  = req;
        v.done = done;
        v.exp  = exp;
        tbl.push_back(v);
    endtask

    // One clock: drive inputs, compare on the falling edge, then let the rising edge act.
    task automatic cyc(input string name, input logic rst, input logic [N-1:0] req,
                       input logic [N-1:0] done, input logic [OW-1:0] exp);
        logic [OW-1:0] act;
        resetn          = rst;
        bus.req         = req;
        bus.drawer_done = done;
        @(negedge clk);
        act = obs();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {en,clr,we,col,crd,sd,busy}=%h expected %h", name, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Source 1: three writes, hold, ack, then no redraw while req stays high.
        add("reset state", 0, Z,    Z,    ex(Z, Z, -1, Z, 0));
        add("idle req1",   0, M_S1, Z,    ex(Z, Z, -1, Z, 0));
        add("clear1",      0, M_S1, Z,    ex(Z, M_S1, -1, Z, 1));
        add("draw1a",      0, M_S1, Z,    ex(M_S1, Z, -1, Z, 1));
        add("draw1b",      0, M_S1, M_S1C, ex(M_S1, Z, SRC_S1_START, Z, 1));
        add("draw1c",      0, M_S1, M_S1, ex(M_S1, Z, SRC_S1_START, Z, 1));
`ifdef OVERLAY_HOLD_EN
        add("hold1a",      0, M_S1, Z,    ex(Z, Z, SRC_S1_START, Z, 1));
        add("hold1b",      0, M_S1, Z,    ex(Z, Z, -1, Z, 1));
        add("hold1c",      0, M_S1, Z,    ex(Z, Z, -1, Z, 1));
        add("hold1d",      0, M_S1, Z,    ex(Z, Z, -1, Z, 1));
        add("done1",       0, M_S1, Z,    ex(Z, Z, -1, M_S1, 1));
`else
        add("done1",       0, M_S1, Z,    ex(Z, Z, SRC_S1_START, M_S1, 1));
`endif
        add("rel1a",       0, M_S1, Z,    ex(Z, Z, -1, Z, 1));
        add("rel1b",       0, M_S1, Z,    ex(Z, Z, -1, Z, 1));
        add("rel1 drop",   0, Z,    Z,    ex(Z, Z, -1, Z, 1));
        add("idle low",    0, Z,    Z,    ex(Z, Z, -1, Z, 0));
        add("rereq1",      0, M_S1, Z,    ex(Z, Z, -1, Z, 0));
        add("reclear1",    0, M_S1, Z,    ex(Z, M_S1, -1, Z, 1));
        add("abort draw1", 0, Z,    Z,    ex(M_S1, Z, -1, Z, 1));
        add("idle abort1", 0, Z,    Z,    ex(Z, Z, -1, Z, 0));
        // Source 5 drops its request after a pixel was written.
        add("idle req5",   0, M_S3S, Z,   ex(Z, Z, -1, Z, 0));
        add("clear5",      0, M_S3S, Z,   ex(Z, M_S3S, -1, Z, 1));
        add("draw5a",      0, M_S3S, Z,   ex(M_S3S, Z, -1, Z, 1));
        add("draw5b",      0, M_S3S, Z,   ex(M_S3S, Z, SRC_S3_START, Z, 1));
        add("drop5",       0, Z,     Z,   ex(M_S3S, Z, SRC_S3_START, Z, 1));
        add("idle abort5", 0, Z,     Z,   ex(Z, Z, -1, Z, 0));
        // Sources 2 and 8 together: 2 wins, 8 waits until req[2] falls.
        add("req2+8",      0, M_S1C | M_LOSE, Z, ex(Z, Z, -1, Z, 0));
        add("clear2",      0, M_S1C | M_LOSE, Z, ex(Z, M_S1C, -1, Z, 1));
        add("draw2a",      0, M_S1C | M_LOSE, Z, ex(M_S1C, Z, -1, Z, 1));
        add("draw2b",      0, M_S1C | M_LOSE, M_S1C | M_LOSE, ex(M_S1C, Z, SRC_S1_CLEAR, Z, 1));
`ifdef OVERLAY_HOLD_EN
        add("hold2a",      0, M_S1C | M_LOSE, Z, ex(Z, Z, SRC_S1_CLEAR, Z, 1));
        add("hold2b",      0, M_S1C | M_LOSE, Z, ex(Z, Z, -1, Z, 1));
        add("hold2c",      0, M_S1C | M_LOSE, Z, ex(Z, Z, -1, Z, 1));
        add("hold2d",      0, M_S1C | M_LOSE, Z, ex(Z, Z, -1, Z, 1));
        add("done2",       0, M_S1C | M_LOSE, Z, ex(Z, Z, -1, M_S1C, 1));
`else
        add("done2",       0, M_S1C | M_LOSE, Z, ex(Z, Z, SRC_S1_CLEAR, M_S1C, 1));
`endif
        add("rel2",        0, M_S1C | M_LOSE, Z, ex(Z, Z, -1, Z, 1));
        add("rel2 drop",   0, M_LOSE, Z,  ex(Z, Z, -1, Z, 1));
        add("grant8",      0, M_LOSE, Z,  ex(Z, Z, -1, Z, 0));
        add("clear8",      0, M_LOSE, Z,  ex(Z, M_LOSE, -1, Z, 1));

        resetn          = 1'b1;
        bus.req         = '0;
        bus.drawer_done = '0;
        for (int i = 0; i < N; i++) begin
            bus.drawer_colour[i*CW +: CW] = col_of(i);
            bus.drawer_coord[i*KW +: KW]  = crd_of(i);
        end
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;

        foreach (tbl[i]) cyc(tbl[i].name, tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].exp);

        // Reset while source 8 is drawing; its request is re-granted afterwards.
        cyc("draw8a",      0, M_LOSE, Z, ex(M_LOSE, Z, -1, Z, 1));
        cyc("draw8b",      0, M_LOSE, Z, ex(M_LOSE, Z, SRC_LOSE, Z, 1));
        cyc("rst in draw", 1, M_LOSE, Z, ex(M_LOSE, Z, SRC_LOSE, Z, 1));
        cyc("after rst8",  0, M_LOSE, Z, ex(Z, Z, -1, Z, 0));
        cyc("regrant8",    0, M_LOSE, Z, ex(Z, M_LOSE, -1, Z, 1));
        cyc("drop8",       0, Z,      Z, ex(M_LOSE, Z, -1, Z, 1));
        cyc("idle end8",   0, Z,      Z, ex(Z, Z, -1, Z, 0));

`ifdef OVERLAY_HOLD_EN
        // Abort during HOLD: no acknowledge.
        cyc("gpa idle",    0, M_GPA, Z,     ex(Z, Z, -1, Z, 0));
        cyc("gpa clear",   0, M_GPA, Z,     ex(Z, M_GPA, -1, Z, 1));
        cyc("gpa draw",    0, M_GPA, M_GPA, ex(M_GPA, Z, -1, Z, 1));
        cyc("gpa hold1",   0, M_GPA, Z,     ex(Z, Z, SRC_SAVE_GPA, Z, 1));
        cyc("gpa hold2",   0, Z,     Z,     ex(Z, Z, -1, Z, 1));
        cyc("gpa aborted", 0, Z,     Z,     ex(Z, Z, -1, Z, 0));
        // Reset during HOLD: outputs clear, held request restarts with CLEAR.
        cyc("gpa idle2",   0, M_GPA, Z,     ex(Z, Z, -1, Z, 0));
        cyc("gpa clear2",  0, M_GPA, Z,     ex(Z, M_GPA, -1, Z, 1));
        cyc("gpa draw2",   0, M_GPA, M_GPA, ex(M_GPA, Z, -1, Z, 1));
        cyc("gpa hold2a",  0, M_GPA, Z,     ex(Z, Z, SRC_SAVE_GPA, Z, 1));
        cyc("rst in hold", 1, M_GPA, Z,     ex(Z, Z, -1, Z, 1));
        cyc("after rsth",  0, M_GPA, Z,     ex(Z, Z, -1, Z, 0));
        cyc("gpa reclear", 0, M_GPA, Z,     ex(Z, M_GPA, -1, Z, 1));
        cyc("gpa drop",    0, Z,     Z,     ex(M_GPA, Z, -1, Z, 1));
        cyc("gpa end",     0, Z,     Z,     ex(Z, Z, -1, Z, 0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
